// File: rtl/picorv32_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : picorv32_bus_pkg
// Description : Shared types and helpers for the picorv32 bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package picorv32_bus_pkg;

   // Arbiter transaction states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   // Read data handed back when the slave never acknowledges
   localparam logic [31:0] C_DEFAULT_TIMEOUT_RDATA = 32'hDEAD_BEEF;

   // Width of a master index; at least one bit
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/picorv32_bus_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Rotating-priority encoder. Returns the first set request bit
//               scanning upward from last+1 with wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
   parameter int NUM_MASTERS = 4,
   parameter int IDX_W       = 2
) (
   input  logic [NUM_MASTERS-1:0] req,
   input  logic [IDX_W-1:0]       last,
   output logic                   any,
   output logic [IDX_W-1:0]       idx
);

   int w_cand;

   // Scan last+1 .. last+NUM_MASTERS; the first hit wins
   always_comb begin
      any    = 1'b0;
      idx    = '0;
      w_cand = 0;
      for (int k = 1; k <= NUM_MASTERS; k++) begin
         w_cand = (int'(last) + k) % NUM_MASTERS;
         if (!any && req[IDX_W'(w_cand)]) begin
            any = 1'b1;
            idx = IDX_W'(w_cand);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/picorv32_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : picorv32_bus_arbiter
// Description : Four-master round-robin arbiter on the picorv32 native memory
//               interface with a slave-acknowledge watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module picorv32_bus_arbiter
   import picorv32_bus_pkg::*;
#(
   parameter int          NUM_MASTERS   = 4,
   parameter int          ADDR_W        = 32,
   parameter int          DATA_W        = 32,
   parameter int          TIMEOUT       = 64,
   parameter logic [31:0] TIMEOUT_RDATA = C_DEFAULT_TIMEOUT_RDATA,
   localparam int         GRANT_W       = idx_width(NUM_MASTERS),
   localparam int         STRB_W        = DATA_W / 8
) (
   input  logic                            clk,
   input  logic                            resetn,
   input  logic [NUM_MASTERS-1:0]          s_valid,
   output logic [NUM_MASTERS-1:0]          s_ready,
   input  logic [NUM_MASTERS*ADDR_W-1:0]   s_addr,
   input  logic [NUM_MASTERS*DATA_W-1:0]   s_wdata,
   input  logic [NUM_MASTERS*STRB_W-1:0]   s_wstrb,
   output logic [NUM_MASTERS*DATA_W-1:0]   s_rdata,
   output logic                            m_valid,
   input  logic                            m_ready,
   output logic [ADDR_W-1:0]               m_addr,
   output logic [DATA_W-1:0]               m_wdata,
   output logic [STRB_W-1:0]               m_wstrb,
   input  logic [DATA_W-1:0]               m_rdata,
   output logic [GRANT_W-1:0]              m_grant,
   output logic                            timeout_pulse,
   output logic [GRANT_W-1:0]              timeout_master
);

   // Watchdog wide enough to hold TIMEOUT-1; last count value fires it
   localparam int WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

   arb_state_t                r_state;
   arb_state_t                w_state_nxt;
   logic [GRANT_W-1:0]        r_last_grant;
   logic [WD_W-1:0]           r_watchdog;
   logic                      w_any;
   logic [GRANT_W-1:0]        w_idx;
   logic                      w_timeout;

   rr_pick #(
      .NUM_MASTERS (NUM_MASTERS),
      .IDX_W       (GRANT_W)
   ) u_rr_pick (
      .req  (s_valid),
      .last (r_last_grant),
      .any  (w_any),
      .idx  (w_idx)
   );

   assign w_timeout = (TIMEOUT != 0) && (r_watchdog == WD_W'(TO_LAST));

   // State register
   always_ff @(posedge clk) begin
      if (!resetn) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   // Next-state: grant, wait for ack or watchdog, one response cycle
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_any) w_state_nxt = BUSY;
         BUSY:    if (m_ready || w_timeout) w_state_nxt = RESP;
         RESP:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Request latch, response return and watchdog
   always_ff @(posedge clk) begin
      if (!resetn) begin
         s_ready        <= '0;
         s_rdata        <= '0;
         m_valid        <= 1'b0;
         m_addr         <= '0;
         m_wdata        <= '0;
         m_wstrb        <= '0;
         m_grant        <= '0;
         timeout_pulse  <= 1'b0;
         timeout_master <= '0;
         r_watchdog     <= '0;
         r_last_grant   <= GRANT_W'(NUM_MASTERS - 1);
      end else begin
         s_ready       <= '0;
         timeout_pulse <= 1'b0;
         case (r_state)
            IDLE: begin
               r_watchdog <= '0;
               if (w_any) begin
                  m_addr       <= s_addr[int'(w_idx)*ADDR_W +: ADDR_W];
                  m_wdata      <= s_wdata[int'(w_idx)*DATA_W +: DATA_W];
                  m_wstrb      <= s_wstrb[int'(w_idx)*STRB_W +: STRB_W];
                  m_grant      <= w_idx;
                  r_last_grant <= w_idx;
                  m_valid      <= 1'b1;
               end
            end
            BUSY: begin
               r_watchdog <= r_watchdog + 1'b1;
               if (m_ready) begin
                  s_rdata[int'(m_grant)*DATA_W +: DATA_W] <= m_rdata;
                  s_ready[m_grant] <= 1'b1;
                  m_valid          <= 1'b0;
               end else if (w_timeout) begin
                  s_rdata[int'(m_grant)*DATA_W +: DATA_W] <= DATA_W'(TIMEOUT_RDATA);
                  s_ready[m_grant] <= 1'b1;
                  timeout_pulse    <= 1'b1;
                  timeout_master   <= m_grant;
                  m_valid          <= 1'b0;
               end
            end
            default: begin
               r_watchdog <= '0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/picorv32_bus_arbiter.md
Name: picorv32_bus_arbiter

Overview:
Four-master, one-slave round-robin arbiter on the PicoRV32 native memory interface (valid/ready/addr/wdata/wstrb/rdata). Sits between the four picorv32 cores and a single shared memory/IO slave, replacing the per-core private memories. It registers one request at a time, forwards it to the slave, and returns the read data plus a one-cycle ready pulse to the granted core. A watchdog completes transactions that the slave never acknowledges, so unmapped accesses cannot hang a core.

Parameters:
NUM_MASTERS, 4, number of master ports (2..8)
ADDR_W, 32, address width
DATA_W, 32, data width; strobe width is DATA_W/8
TIMEOUT, 64, slave-ack watchdog in cycles; 0 disables it
TIMEOUT_RDATA, 32'hDEAD_BEEF, read data returned on timeout

Ports:
clk  in  1  clock
resetn  in  1  synchronous, active-low reset
s_valid  in  NUM_MASTERS  per-master mem_valid
s_ready  out  NUM_MASTERS  per-master mem_ready, one-cycle pulse
s_addr  in  NUM_MASTERS*ADDR_W  flattened per-master mem_addr; master i occupies slice i
s_wdata  in  NUM_MASTERS*DATA_W  flattened per-master mem_wdata
s_wstrb  in  NUM_MASTERS*DATA_W/8  flattened per-master mem_wstrb
s_rdata  out  NUM_MASTERS*DATA_W  flattened per-master mem_rdata, held between transactions
m_valid  out  1  slave request valid
m_ready  in  1  slave acknowledge
m_addr  out  ADDR_W  registered address of the granted request
m_wdata  out  DATA_W  registered write data of the granted request
m_wstrb  out  DATA_W/8  registered write strobes of the granted request
m_rdata  in  DATA_W  slave read data, sampled when m_ready=1
m_grant  out  $clog2(NUM_MASTERS)  index of the granted master; the slave uses it to route per-core IO such as the LED registers
timeout_pulse  out  1  one-cycle pulse when the watchdog fires
timeout_master  out  $clog2(NUM_MASTERS)  master index of the last timeout

Behaviour:
- Reset (resetn=0 at a clk edge) sets:
  - state=IDLE; s_ready=0; s_rdata=0; m_valid=0; m_addr, m_wdata, m_wstrb = 0
  - m_grant=0; timeout_pulse=0; timeout_master=0; watchdog=0
  - last_grant=NUM_MASTERS-1, so master 0 wins first
- Reset mid-transaction abandons it: m_valid is 0 after that edge and no s_ready is issued.
- States:
  - IDLE: if any s_valid bit is set, pick the first requester scanning from last_grant+1 with wrap-around. Latch its addr/wdata/wstrb into m_*, set m_grant and last_grant, m_valid<=1, go to BUSY. With no requests, stay in IDLE.
  - BUSY: m_valid=1, m_* stable. The watchdog increments each cycle.
    - m_ready=1: s_rdata[g]<=m_rdata, s_ready[g]<=1, m_valid<=0, go to RESP.
    - Otherwise, if TIMEOUT!=0 and watchdog==TIMEOUT-1: s_rdata[g]<=TIMEOUT_RDATA, s_ready[g]<=1, timeout_pulse<=1, timeout_master<=g, m_valid<=0, go to RESP.
    - m_ready takes priority over timeout in the same cycle.
  - RESP: s_ready, timeout_pulse, watchdog return to 0; go to IDLE. This gives the core one edge to drop mem_valid, so the same request is never granted twice.
- s_rdata[i] changes only on master i's completion; otherwise it is held. This supports LATCHED_MEM_RDATA=1.
- Write completions also load s_rdata[g] from m_rdata; cores ignore rdata on writes.
- Latency: request sampled in IDLE at cycle 0 -> m_valid at cycle 1 -> slave with a 1-cycle ack gives m_ready at cycle 2 -> s_ready at cycle 3. Best case is one transaction per 4 cycles.
- At most one s_ready bit is set in any cycle.
- A non-granted master's s_valid is ignored until it is picked. A granted master dropping s_valid (illegal for picorv32) does not abort the slave transaction.
- Round-robin guarantees each continuously requesting master is served within NUM_MASTERS grants.

Decomposition:
- Package picorv32_bus_pkg: state enum (IDLE, BUSY, RESP), the default TIMEOUT_RDATA constant, and a helper function for grant-index width.
- One sub-module rr_pick: combinational rotate-priority encoder. Inputs req[NUM_MASTERS] and last[idx]; outputs any and idx. Kept separate for unit testing.

Test Plan:
- Reset then s_valid=4'b0001, addr 0x10, wstrb 0, slave acks 1 cycle after m_valid with m_rdata=0x12345678 -> m_addr=0x10 at cycle 1, s_ready[0] pulses at cycle 3, s_rdata slice0=0x12345678 and held afterwards.
- All four s_valid asserted together and held until each core's ready -> grant order 0,1,2,3; m_grant matches; exactly one s_ready per transaction.
- Masters 0 and 2 re-request immediately after each ready -> grants alternate 0,2,0,2; master 0 never wins twice in a row.
- Master 1 write, addr 0x1000_0000, wdata 0xA5, wstrb 4'b0001 -> m_addr/m_wdata/m_wstrb match exactly, m_grant=1.
- TIMEOUT=8, slave never acks, master 3 read -> after 8 BUSY cycles s_ready[3] pulses, s_rdata slice3=0xDEADBEEF, timeout_pulse=1, timeout_master=3. Then master 0 is granted normally.
- resetn low for one cycle while in BUSY -> m_valid=0 next cycle, no s_ready, and master 0 is granted first afterward.
